// File: rtl/pu_riscv_ahb3_sram_slave_if.sv
// AHB3-Lite bus bundle between a PU bus port (master) and the SRAM responder (slave).
interface pu_riscv_ahb3_sram_slave_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/pu_riscv_ahb3_sram_slave.sv
// AHB3-Lite SRAM responder: single-port array, configurable wait states,
// byte/halfword/word access and two-cycle ERROR response for illegal transfers.
module pu_riscv_ahb3_sram_slave #(
  parameter int unsigned HADDR_SIZE  = 32,
  parameter int unsigned HDATA_SIZE  = 32,
  parameter int unsigned MEM_SIZE    = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                       HCLK,
  input logic                       HRESETn,
  pu_riscv_ahb3_sram_slave_if.slave bus
);

  localparam int unsigned BYTES      = HDATA_SIZE / 8;
  localparam int unsigned OFF_BITS   = $clog2(BYTES);
  localparam int unsigned MEM_WORDS  = MEM_SIZE / BYTES;
  localparam int unsigned WADDR_BITS = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [2:0]            SIZE_MAX  = 3'(OFF_BITS);
  localparam logic [2:0]            WS        = 3'(WAIT_STATES);
  localparam logic [HADDR_SIZE-1:0] MEM_LIMIT = HADDR_SIZE'(MEM_SIZE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]            state, next_state;
  logic [2:0]            cnt, cnt_next;
  logic [WADDR_BITS-1:0] waddr_q;
  logic [BYTES-1:0]      mask_q;
  logic                  write_q;
  logic                  legal_q;

  logic                  accept_c;
  logic                  legal_c;
  logic                  misaligned_c;
  logic [7:0]            size_base_c;
  logic [BYTES-1:0]      mask_c;
  logic                  open_c;

  logic [HDATA_SIZE-1:0] mem [MEM_WORDS];

  // Sideband signals that carry no meaning for a plain SRAM
  logic unused_sideband;
  assign unused_sideband = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  // Address-phase decode: acceptance, legality and little-endian lane mask
  always_comb begin
    size_base_c  = 8'h00;
    misaligned_c = 1'b0;
    case (bus.HSIZE)
      3'd0: size_base_c = 8'h01;
      3'd1: begin size_base_c = 8'h03; misaligned_c = bus.HADDR[0];    end
      3'd2: begin size_base_c = 8'h0F; misaligned_c = |bus.HADDR[1:0]; end
      3'd3: begin size_base_c = 8'hFF; misaligned_c = |bus.HADDR[2:0]; end
      default: ;
    endcase
    open_c   = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
    accept_c = open_c && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    legal_c  = (bus.HADDR < MEM_LIMIT) && (bus.HSIZE <= SIZE_MAX) && !misaligned_c;
    mask_c   = BYTES'(size_base_c << bus.HADDR[OFF_BITS-1:0]);
  end

  // State and wait counter register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; a completing data phase may accept the next transfer back-to-back
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE, S_LAST, S_ERR2: begin
        next_state = S_IDLE;
        cnt_next   = 3'd0;
        if (accept_c) begin
          if (!legal_c) begin
            next_state = S_ERR1;
          end else if (WS != 3'd0) begin
            next_state = S_WAIT;
            cnt_next   = WS;
          end else begin
            next_state = S_LAST;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 3'd1) begin
          next_state = S_LAST;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      S_ERR1:  next_state = S_ERR2;
      default: next_state = S_IDLE;
    endcase
  end

  // Capture the accepted transfer for its data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      waddr_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
    end else if (accept_c) begin
      waddr_q <= bus.HADDR[OFF_BITS +: WADDR_BITS];
      mask_q  <= mask_c;
      write_q <= bus.HWRITE;
      legal_q <= legal_c;
    end
  end

  // Array write on the edge closing a legal write data phase; contents survive reset
  always_ff @(posedge HCLK) begin
    if (state == S_LAST && write_q && legal_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (mask_q[i]) mem[waddr_q][i*8 +: 8] <= bus.HWDATA[i*8 +: 8];
      end
    end
  end

  // Response decode from state; read data only during the completing read cycle
  always_comb begin
    bus.HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
    bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);
    bus.HRDATA    = '0;
    if (state == S_LAST && !write_q) bus.HRDATA = mem[waddr_q];
  end

endmodule

// File: tb/tb_pu_riscv_ahb3_sram_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) share one AHB bus.
module tb_pu_riscv_ahb3_sram_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  tgt = 2'd0;
  logic [1:0]  trans = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [2:0]  size = 3'd2;
  logic        hready, hresp;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pu_riscv_ahb3_sram_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus0 ();
  pu_riscv_ahb3_sram_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus1 ();
  pu_riscv_ahb3_sram_slave_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus2 ();

  assign hready = bus0.HREADYOUT & bus1.HREADYOUT & bus2.HREADYOUT;
  assign hresp  = bus0.HRESP | bus1.HRESP | bus2.HRESP;
  assign hrdata = bus0.HRDATA | bus1.HRDATA | bus2.HRDATA;

  assign bus0.HSEL = (tgt == 2'd0);
  assign bus1.HSEL = (tgt == 2'd1);
  assign bus2.HSEL = (tgt == 2'd2);
  assign bus0.HADDR = addr;  assign bus1.HADDR = addr;  assign bus2.HADDR = addr;
  assign bus0.HWDATA = wdata; assign bus1.HWDATA = wdata; assign bus2.HWDATA = wdata;
  assign bus0.HWRITE = wr;   assign bus1.HWRITE = wr;   assign bus2.HWRITE = wr;
  assign bus0.HSIZE = size;  assign bus1.HSIZE = size;  assign bus2.HSIZE = size;
  assign bus0.HTRANS = trans; assign bus1.HTRANS = trans; assign bus2.HTRANS = trans;
  assign bus0.HBURST = 3'd0; assign bus1.HBURST = 3'd0; assign bus2.HBURST = 3'd0;
  assign bus0.HPROT = 4'd0;  assign bus1.HPROT = 4'd0;  assign bus2.HPROT = 4'd0;
  assign bus0.HMASTLOCK = 1'b0; assign bus1.HMASTLOCK = 1'b0; assign bus2.HMASTLOCK = 1'b0;
  assign bus0.HREADY = hready; assign bus1.HREADY = hready; assign bus2.HREADY = hready;

  pu_riscv_ahb3_sram_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_SIZE(4096), .WAIT_STATES(0))
    dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(bus0));
  pu_riscv_ahb3_sram_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_SIZE(4096), .WAIT_STATES(2))
    dut1 (.HCLK(clk), .HRESETn(rst_n), .bus(bus1));
  pu_riscv_ahb3_sram_slave #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MEM_SIZE(4096), .WAIT_STATES(3))
    dut2 (.HCLK(clk), .HRESETn(rst_n), .bus(bus2));

  typedef struct {
    logic [1:0]  tgt;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  localparam logic [1:0] IDL = 2'd0;
  localparam logic [1:0] BSY = 2'd1;
  localparam logic [1:0] NSQ = 2'd2;

  function automatic vec_t mk(input logic [1:0] t, input logic [1:0] tr, input logic [31:0] a,
                              input logic w, input logic [2:0] s, input logic [31:0] d,
                              input logic rdy, input logic rsp, input logic [31:0] rd);
    vec_t v;
    v.tgt = t; v.trans = tr; v.addr = a; v.wr = w; v.size = s; v.wdata = d;
    v.exp_rdy = rdy; v.exp_resp = rsp; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the edge, sample at the falling edge
  task automatic apply(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    tgt = v.tgt; trans = v.trans; addr = v.addr; wr = v.wr; size = v.size; wdata = v.wdata;
    @(negedge clk);
    check({tag, "_rdy"},   32'(hready), 32'(v.exp_rdy));
    check({tag, "_resp"},  32'(hresp),  32'(v.exp_resp));
    check({tag, "_rdata"}, hrdata,      v.exp_rdata);
  endtask

  initial begin
    // 0 wait states: write/read back-to-back, byte and halfword merge
    tbl.push_back(mk(0, NSQ, 32'h10, 1, 3'd2, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, NSQ, 32'h10, 0, 3'd2, 32'hDEADBEEF, 1, 0, 32'h0));
    tbl.push_back(mk(0, NSQ, 32'h13, 1, 3'd0, 32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, NSQ, 32'h10, 0, 3'd2, 32'hAA000000, 1, 0, 32'h0));
    tbl.push_back(mk(0, NSQ, 32'h10, 1, 3'd1, 32'h0,        1, 0, 32'hAAADBEEF));
    tbl.push_back(mk(0, NSQ, 32'h10, 0, 3'd2, 32'h00001234, 1, 0, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'hAAAD1234));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0));
    // Out-of-range read
    tbl.push_back(mk(0, NSQ, 32'h1000, 0, 3'd2, 32'h0,      1, 0, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 1, 32'h0));
    // Misaligned halfword write must not touch the array; read issued from ERR2
    tbl.push_back(mk(0, NSQ, 32'h11, 1, 3'd1, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'hFFFFFFFF, 0, 1, 32'h0));
    tbl.push_back(mk(0, NSQ, 32'h10, 0, 3'd2, 32'hFFFFFFFF, 1, 1, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'hAAAD1234));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0));
    // Oversize transfer (doubleword on a 32-bit bus)
    tbl.push_back(mk(0, NSQ, 32'h18, 0, 3'd3, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 1, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 1, 32'h0));
    // Last word of the array is legal
    tbl.push_back(mk(0, NSQ, 32'hFFC, 1, 3'd2, 32'h0,       1, 0, 32'h0));
    tbl.push_back(mk(0, NSQ, 32'hFFC, 0, 3'd2, 32'h01020304, 1, 0, 32'h0));
    tbl.push_back(mk(0, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h01020304));
    // 2 wait states: write, held read, then IDLE/BUSY get zero-wait OKAY
    tbl.push_back(mk(1, NSQ, 32'h10, 1, 3'd2, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, NSQ, 32'h10, 0, 3'd2, 32'hCAFEF00D, 0, 0, 32'h0));
    tbl.push_back(mk(1, NSQ, 32'h10, 0, 3'd2, 32'hCAFEF00D, 0, 0, 32'h0));
    tbl.push_back(mk(1, NSQ, 32'h10, 0, 3'd2, 32'hCAFEF00D, 1, 0, 32'h0));
    tbl.push_back(mk(1, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(1, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 0, 32'h0));
    tbl.push_back(mk(1, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, IDL, 32'h10, 0, 3'd2, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, BSY, 32'h10, 0, 3'd2, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0));
    // 3 wait states: seed word 0x20
    tbl.push_back(mk(2, NSQ, 32'h20, 1, 3'd2, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(2, IDL, 32'h0,  0, 3'd2, 32'h0BADF00D, 0, 0, 32'h0));
    tbl.push_back(mk(2, IDL, 32'h0,  0, 3'd2, 32'h0BADF00D, 0, 0, 32'h0));
    tbl.push_back(mk(2, IDL, 32'h0,  0, 3'd2, 32'h0BADF00D, 0, 0, 32'h0));
    tbl.push_back(mk(2, IDL, 32'h0,  0, 3'd2, 32'h0BADF00D, 1, 0, 32'h0));
    tbl.push_back(mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0));

    // Power-on reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("por_rdy",   32'(hready), 32'd1);
    check("por_resp",  32'(hresp),  32'd0);
    check("por_rdata", hrdata,      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Write to 0x20 aborted by reset during its second wait cycle
    apply("abort_addr", mk(2, NSQ, 32'h20, 1, 3'd2, 32'h0,   1, 0, 32'h0));
    apply("abort_w1",   mk(2, IDL, 32'h0,  0, 3'd2, 32'h55555555, 0, 0, 32'h0));
    apply("abort_w2",   mk(2, IDL, 32'h0,  0, 3'd2, 32'h55555555, 0, 0, 32'h0));
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rdy",   32'(hready), 32'd1);
    check("rst_mid_resp",  32'(hresp),  32'd0);
    check("rst_mid_rdata", hrdata,      32'h0);
    #1 rst_n = 1'b1;
    apply("post_a",  mk(2, NSQ, 32'h20, 0, 3'd2, 32'h55555555, 1, 0, 32'h0));
    apply("post_w1", mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 0, 32'h0));
    apply("post_w2", mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 0, 32'h0));
    apply("post_w3", mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        0, 0, 32'h0));
    apply("post_rd", mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0BADF00D));
    apply("post_id", mk(2, IDL, 32'h0,  0, 3'd2, 32'h0,        1, 0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_riscv_ahb3_sram_slave.md
Name: pu_riscv_ahb3_sram_slave

Overview:
AHB3-Lite responder (slave) that terminates one PU bus port (instruction or data) with a local single-port SRAM array. It decodes address-phase transfers and inserts a configurable number of wait states. It performs byte, halfword and word reads and writes, and issues the two-cycle AHB ERROR response for illegal transfers. It is used in PU-level testbenches and as tightly-coupled boot/scratch memory in small SoCs.

Parameters:
HADDR_SIZE, 32, address width; matches PU PLEN.
HDATA_SIZE, 32, data width; matches PU XLEN; 32 or 64.
MEM_SIZE, 4096, memory size in bytes; power of two, at least HDATA_SIZE/8.
WAIT_STATES, 0, wait cycles per accepted transfer; range 0..7.

Ports:
HCLK  input  1  bus clock; all state changes on its rising edge.
HRESETn  input  1  asynchronous active-low reset.
HSEL  input  1  slave select.
HADDR  input  HADDR_SIZE  transfer address; the offset is HADDR mod MEM_SIZE only when HADDR < MEM_SIZE.
HWDATA  input  HDATA_SIZE  write data; valid in the data phase.
HRDATA  output  HDATA_SIZE  read data.
HWRITE  input  1  1 = write.
HSIZE  input  3  transfer size.
HBURST  input  3  ignored; every beat is decoded on its own.
HPROT  input  4  ignored.
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HMASTLOCK  input  1  ignored.
HREADY  input  1  bus-level ready; qualifies the address phase.
HREADYOUT  output  1  slave ready.
HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Transfer acceptance: a transfer is accepted on a rising edge where HSEL=1, HREADY=1 and HTRANS[1]=1. IDLE and BUSY are not accepted and get a zero-wait OKAY response.
- Error check, evaluated at acceptance. A transfer is illegal if any of the following holds; otherwise it is legal.
  - HADDR >= MEM_SIZE.
  - HSIZE > log2(HDATA_SIZE/8).
  - HADDR is not aligned to 2^HSIZE.
- Registered at acceptance: word address, byte-lane mask (little-endian, from HSIZE and the low HADDR bits), HWRITE, and the legal/illegal flag.
- State machine states: IDLE, WAIT, LAST, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
  - Legal transfer accepted: go to WAIT if WAIT_STATES>0, otherwise LAST; a counter is loaded with WAIT_STATES.
  - Illegal transfer accepted: go to ERR1.
- WAIT: HREADYOUT=0, HRESP=0; the counter decrements each cycle; go to LAST when it reaches 1.
- LAST: HREADYOUT=1, HRESP=0. This is the completing data-phase cycle.
  - Write: the masked lanes of HWDATA are written to the array on the closing edge.
  - Read: HRDATA = array[registered word address], read combinationally from the registered address.
  - New-transfer decision on the closing edge: if a new transfer is accepted, re-enter WAIT, LAST or ERR1 as above (back-to-back pipelining); otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1; go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1; the array is never modified by an illegal transfer. The new-transfer decision is the same as in LAST.
- Read-after-write: a write commits on the edge that ends its data phase, and a following read samples the array during its own data phase. A read directly after a write to the same word therefore returns the new data with no extra stall.
- HRDATA value: driven 0 in every cycle except LAST of a read. All lanes are returned for a read, not only the masked ones.
- Reset:
  - HRESETn low immediately forces IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and counter=0.
  - A write in progress (in WAIT or LAST before its closing edge) is discarded.
  - Array contents are not reset.
- Wrap-around: none; addresses at or above MEM_SIZE error and never alias.

Test Plan:
- Reset: HRESETn=0 mid-simulation -> HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously (before the next HCLK edge).
- WAIT_STATES=0, back-to-back: NONSEQ word write 0xDEADBEEF to 0x10, followed immediately by a NONSEQ read of 0x10 -> HREADYOUT stays 1 throughout; the read data phase returns 0xDEADBEEF.
- Byte write, following the previous scenario: HSIZE=0 write to 0x13 with HWDATA=0xAA000000, then a word read of 0x10 -> returns 0xAAADBEEF. A halfword write of 0x1234 to 0x10 followed by a read -> returns 0xAAAD1234.
- WAIT_STATES=2, word read of 0x10 -> HREADYOUT=0 for exactly 2 cycles, then 1 with HRDATA valid; an IDLE transfer during the same run gets a zero-wait OKAY.
- Errors:
  - Read of 0x1000 with MEM_SIZE=4096 -> HREADYOUT/HRESP sequence 0/1 then 1/1.
  - Halfword write to 0x11 -> the same two-cycle error; a subsequent read of 0x10 shows the word unchanged.
- Reset mid-operation: WAIT_STATES=3, word write of 0x55555555 to 0x20 with HRESETn pulsed low during the second wait cycle -> HREADYOUT=1 immediately; a later read of 0x20 returns the old value.
